// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-sequencer types and constants: sequencer state
//               encoding, PC increment and default vector addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Fetch sequencer states: BOOT idles one cycle after reset, RUN fetches
  // sequentially, SLOT waits for the delay-slot fetch before redirecting.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    SLOT = 2'd2
  } state_e;

  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// Module      : pc_next_sel
// Description : Combinational priority selector for the next PC and sequencer
//               state. Priority: exception > redirect > advance > hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = DATA_WIDTH'(DEF_EXC_VECTOR)
) (
  input  state_e                state_i,
  input  logic                  exc_i,
  input  logic                  redirect_i,
  input  logic                  delay_i,
  input  logic                  advance_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pending_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output state_e                next_state_o,
  output logic                  epc_capture_o,
  output logic                  pend_load_o,
  output logic                  pend_clear_o,
  output logic                  slot_err_o,
  output logic [DATA_WIDTH-1:0] target_aligned_o
);

  logic [DATA_WIDTH-1:0] w_target_aligned;

  // Masking keeps every target word aligned regardless of the low address bits.
  assign w_target_aligned = target_i & ~DATA_WIDTH'(3);
  assign target_aligned_o = w_target_aligned;

  // Priority decode of the next PC, next state and register strobes.
  always_comb begin
    next_pc_o     = pc_i;
    next_state_o  = state_i;
    epc_capture_o = 1'b0;
    pend_load_o   = 1'b0;
    pend_clear_o  = 1'b0;
    slot_err_o    = 1'b0;
    case (state_i)
      BOOT: begin
        // All events are ignored while booting.
        next_state_o = RUN;
      end
      RUN: begin
        if (exc_i) begin
          epc_capture_o = 1'b1;
          pend_clear_o  = 1'b1;
          next_pc_o     = EXC_VECTOR;
        end else if (redirect_i) begin
          if (!delay_i || advance_i) begin
            // Immediate flush, or the delay slot is fetched this very cycle.
            next_pc_o = w_target_aligned;
          end else begin
            pend_load_o  = 1'b1;
            next_state_o = SLOT;
          end
        end else if (advance_i) begin
          next_pc_o = pc_i + DATA_WIDTH'(PC_INCR);
        end
      end
      SLOT: begin
        if (exc_i) begin
          epc_capture_o = 1'b1;
          pend_clear_o  = 1'b1;
          next_pc_o     = EXC_VECTOR;
          next_state_o  = RUN;
        end else begin
          // A branch inside a delay slot is dropped but flagged.
          slot_err_o = redirect_i;
          if (advance_i) begin
            next_pc_o    = pending_i;
            next_state_o = RUN;
          end
        end
      end
      default: begin
        next_state_o = BOOT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage PC owner. Holds PC, pending delay-slot target,
//               EPC and sequencer state; drives the imem request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = DATA_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  redirect_delay,
  input  logic                  exc_valid,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] epc,
  output logic                  slot_err
);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pending_q;
  logic [DATA_WIDTH-1:0] pending_d;
  logic [DATA_WIDTH-1:0] epc_q;
  logic                  slot_err_q;
  logic                  w_advance;
  logic                  w_epc_capture;
  logic                  w_pend_load;
  logic                  w_pend_clear;
  logic                  w_slot_err;
  logic [DATA_WIDTH-1:0] w_target_aligned;

  assign imem_req  = (state_q != BOOT) && !stall;
  assign imem_addr = pc_q;
  assign w_advance = imem_req && imem_ready;
  assign epc       = epc_q;
  assign slot_err  = slot_err_q;

  pc_next_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .state_i          (state_q),
    .exc_i            (exc_valid),
    .redirect_i       (redirect_valid),
    .delay_i          (redirect_delay),
    .advance_i        (w_advance),
    .pc_i             (pc_q),
    .pending_i        (pending_q),
    .target_i         (redirect_target),
    .next_pc_o        (pc_d),
    .next_state_o     (state_d),
    .epc_capture_o    (w_epc_capture),
    .pend_load_o      (w_pend_load),
    .pend_clear_o     (w_pend_clear),
    .slot_err_o       (w_slot_err),
    .target_aligned_o (w_target_aligned)
  );

  // Pending target: cleared by an exception, loaded by a deferred redirect.
  always_comb begin
    pending_d = pending_q;
    if (w_pend_clear) begin
      pending_d = '0;
    end else if (w_pend_load) begin
      pending_d = w_target_aligned;
    end
  end

  // Sequencer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      epc_q      <= '0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      slot_err_q <= w_slot_err;
      if (w_epc_capture) begin
        epc_q <= pc_q;
      end
    end
  end

endmodule

`default_nettype wire
